lcg64_core: RTL and testbench

64-bit linear congruential state generator feeding the 32-bit permutation stage of the PRNG64 pipeline. Holds a 64-bit state and advances it by `state*MULT + INC` (mod 2^64) once per accepted output word. It presents `state[63:32]` on a valid/ready output toward the permutation stage. Seeds are loaded through a valid/ready handshake and are followed by a programmable warm-up of discarded steps.

---
 rtl/prng_pkg.sv | 7 +
 rtl/lcg64_step.sv | 12 +
 rtl/lcg64_core.sv | 59 +++++
 tb/tb_lcg64_core.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// prng_pkg: shared constants and types for the PRNG64 pipeline
package prng_pkg;
    localparam logic [63:0] DEF_MULT = 64'h5851F42D4C957F2D;
    localparam logic [63:0] DEF_INC  = 64'h14057B7EF767814F;
    typedef logic [63:0] state_t;
    typedef enum logic [1:0] {IDLE, WARM, RUN} fsm_t;
endpackage

// File: rtl/lcg64_step.sv
// lcg64_step: combinational LCG step, next = state*MULT + INC mod 2^64
module lcg64_step
    import prng_pkg::*;
#(
    parameter logic [63:0] MULT = DEF_MULT,
    parameter logic [63:0] INC  = DEF_INC
) (
    input  state_t state,
    output state_t next
);
    assign next = state * MULT + INC;
endmodule

// File: rtl/lcg64_core.sv
// lcg64_core: 64-bit LCG with seed load, warm-up discard and valid/ready output
module lcg64_core
    import prng_pkg::*;
#(
    parameter logic [63:0] MULT   = DEF_MULT,
    parameter logic [63:0] INC    = DEF_INC,
    parameter int unsigned WARMUP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_valid,
    output logic        seed_ready,
    input  logic [63:0] seed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] word_count
);
    localparam int CW = (WARMUP == 0) ? 1 : $clog2(WARMUP + 1);
    fsm_t          fsm, fsm_n;
    state_t        st, nxt;
    logic [CW-1:0] cnt;
    logic          seed_acc, fire;
    lcg64_step #(.MULT(MULT), .INC(INC)) u_step (.state(st), .next(nxt));
    assign seed_ready = rst && (fsm != WARM);
    assign out_valid  = (fsm == RUN);
    assign out_data   = st[63:32];
    assign seed_acc   = seed_valid && seed_ready;
    assign fire       = out_valid && out_ready;
    // state register of the control FSM
    always_ff @(posedge clk) begin
        if (!rst) fsm <= IDLE;
        else      fsm <= fsm_n;
    end
    // next state: a seed always restarts, warm-up ends when the counter hits zero
    always_comb begin
        fsm_n = fsm;
        if (seed_acc) fsm_n = (WARMUP == 0) ? RUN : WARM;
        else if (fsm == WARM && cnt == CW'(1)) fsm_n = RUN;
    end
    // datapath: seed load has priority over warm-up and output steps
    always_ff @(posedge clk) begin
        if (!rst) begin
            st         <= '0;
            cnt        <= '0;
            word_count <= '0;
        end else if (seed_acc) begin
            st         <= seed;
            cnt        <= CW'(WARMUP);
            word_count <= '0;
        end else if (fsm == WARM) begin
            st  <= nxt;
            cnt <= cnt - CW'(1);
        end else if (fire) begin
            st         <= nxt;
            word_count <= word_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_lcg64_core.sv
// tb_lcg64_core: directed scoreboard bench for lcg64_core in three configurations
module tb_lcg64_core;
    localparam logic [63:0] M = 64'h5851F42D4C957F2D;
    localparam logic [63:0] C = 64'h14057B7EF767814F;
    logic clk = 0, rst = 0;
    logic sv0 = 0, sr0, ov0, or0 = 0;
    logic sv4 = 0, sr4, ov4, or4 = 0;
    logic sv1 = 0, sr1, ov1, or1 = 0;
    logic [63:0] sd0 = 0, sd4 = 0, sd1 = 0;
    logic [31:0] od0, od4, od1, wc0, wc4, wc1;
    int checks = 0, errors = 0;
    logic [31:0] q[$];
    always #5 clk = ~clk;
    lcg64_core #(.WARMUP(0)) d0 (.clk(clk), .rst(rst), .seed_valid(sv0), .seed_ready(sr0), .seed(sd0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .word_count(wc0));
    lcg64_core #(.WARMUP(4)) d4 (.clk(clk), .rst(rst), .seed_valid(sv4), .seed_ready(sr4), .seed(sd4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .word_count(wc4));
    lcg64_core #(.MULT(64'd1), .INC(64'd1), .WARMUP(0)) d1 (.clk(clk), .rst(rst), .seed_valid(sv1),
        .seed_ready(sr1), .seed(sd1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .word_count(wc1));
    // reference step built from shift-and-add so it does not reuse the RTL operator
    function automatic logic [63:0] mstep(input logic [63:0] s, input logic [63:0] m, input logic [63:0] c);
        logic [63:0] p = '0;
        for (int b = 0; b < 64; b++) if (m[b]) p = p + (s << b);
        return p + c;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    initial begin
        logic [63:0] ms;
        logic [31:0] prev, exp;
        logic r;
        int n;
        tick(); tick(); tick();
        chk("rst_seed_ready", sr0, 0);
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_data", od0, 0);
        chk("rst_word_count", wc0, 0);
        rst = 1;
        tick();
        chk("release_seed_ready", sr0, 1);
        for (int i = 0; i < 20; i++) begin
            chk("idle_out_valid", ov4, 0);
            chk("idle_seed_ready", sr4, 1);
            tick();
        end
        // WARMUP=0, seed 0, full throughput
        sd0 = 64'h0; sv0 = 1; or0 = 1;
        ms = 64'h0;
        for (int i = 0; i < 3; i++) begin
            q.push_back(ms[63:32]);
            ms = mstep(ms, M, C);
        end
        tick();
        sv0 = 0;
        for (int i = 0; i < 3; i++) begin
            exp = q.pop_front();
            chk("w0_valid", ov0, 1);
            chk("w0_data", od0, exp);
            chk("w0_count", wc0, i);
            if (i == 1) chk("w0_inc_word", od0, 32'h14057B7E);
            tick();
        end
        // random backpressure against the unstalled sequence
        for (int i = 0; i < 40; i++) begin
            q.push_back(ms[63:32]);
            ms = mstep(ms, M, C);
        end
        n = 3;
        r = 1;
        prev = od0;
        for (int i = 0; i < 40; i++) begin
            chk("bp_valid", ov0, 1);
            chk("bp_data", od0, q[0]);
            chk("bp_count", wc0, n);
            if (!r) chk("bp_stable", od0, prev);
            prev = od0;
            r = 1'($urandom_range(0, 1));
            or0 = r;
            tick();
            if (r) begin
                void'(q.pop_front());
                n++;
            end
        end
        // seed coincident with an output handshake
        chk("reseed_pre_count", wc0, n);
        sd0 = 64'hDEADBEEF_01234567; sv0 = 1; or0 = 1;
        tick();
        sv0 = 0;
        chk("reseed_data", od0, 32'hDEADBEEF);
        chk("reseed_count", wc0, 0);
        chk("reseed_valid", ov0, 1);
        ms = mstep(64'hDEADBEEF_01234567, M, C);
        tick();
        chk("reseed_next_data", od0, ms[63:32]);
        chk("reseed_next_count", wc0, 1);
        // WARMUP=4, seed 0
        sd4 = 64'h0; sv4 = 1; or4 = 1;
        tick();
        sv4 = 0;
        for (int i = 0; i < 4; i++) begin
            chk("warm_valid", ov4, 0);
            chk("warm_seed_ready", sr4, 0);
            tick();
        end
        ms = 64'h0;
        for (int i = 0; i < 4; i++) ms = mstep(ms, M, C);
        chk("warm_first_valid", ov4, 1);
        chk("warm_first_data", od4, ms[63:32]);
        chk("warm_first_count", wc4, 0);
        // MULT=1, INC=1 64-bit wrap
        sd1 = 64'hFFFFFFFF_FFFFFFFF; sv1 = 1; or1 = 1;
        tick();
        sv1 = 0;
        chk("wrap_first", od1, 32'hFFFFFFFF);
        tick();
        chk("wrap_second", od1, 32'h00000000);
        chk("wrap_count", wc1, 1);
        // reset during warm-up
        or4 = 0;
        sd4 = 64'h12345678_9ABCDEF0; sv4 = 1;
        tick();
        sv4 = 0;
        tick();
        chk("rw_in_warm", sr4, 0);
        rst = 0;
        tick();
        chk("rw_valid", ov4, 0);
        chk("rw_data", od4, 0);
        chk("rw_count", wc4, 0);
        chk("rw_seed_ready", sr4, 0);
        rst = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rw_idle_valid", ov4, 0);
            chk("rw_idle_ready", sr4, 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
